// File: rtl/point_referee.sv
// rtl/point_referee.sv - goal detection and rally sequencing feeding the scoreboard.
// One increment_score bit is held for exactly one fsync per goal.
module point_referee #(
   parameter int HRES         = 1280,
   parameter int BALL_SIZE    = 20,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_POINTS   = 10
) (
   input  logic               pixel_clk,
   input  logic               rst,
   input  logic               fsync,
   input  logic signed [11:0] ball_x,
   input  logic               start,
   output logic               increment_score [1:0],
   output logic               ball_freeze,
   output logic               ball_reset,
   output logic               serve_dir,
   output logic               game_over
);

   localparam int CW = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);
   localparam logic signed [12:0] RIGHT_LIMIT = 13'(HRES - BALL_SIZE);

   typedef enum logic [2:0] {
      SERVE_WAIT,
      PLAY,
      SCORE,
      RECENTER,
      GAME_OVER
   } state_t;

   state_t            state, state_next;
   logic [CW-1:0]     cnt, cnt_next;
   logic [3:0]        points [0:1];
   logic [3:0]        points_next [0:1];
   logic              winner, winner_next;
   logic              serve_dir_next;
   logic signed [12:0] bx_wide;
   logic [3:0]        win_pts;
   logic [4:0]        win_pts_inc;

   // Sign-extend so the right-edge compare cannot wrap
   assign bx_wide     = {ball_x[11], ball_x};
   assign win_pts     = winner ? points[1] : points[0];
   assign win_pts_inc = {1'b0, win_pts} + 5'd1;

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         state     <= SERVE_WAIT;
         cnt       <= CW'(SERVE_FRAMES);
         points[0] <= '0;
         points[1] <= '0;
         winner    <= 1'b0;
         serve_dir <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         points[0] <= points_next[0];
         points[1] <= points_next[1];
         winner    <= winner_next;
         serve_dir <= serve_dir_next;
      end
   end

   always_comb begin
      state_next         = state;
      cnt_next           = cnt;
      points_next[0]     = points[0];
      points_next[1]     = points[1];
      winner_next        = winner;
      serve_dir_next     = serve_dir;
      ball_freeze        = 1'b1;
      ball_reset         = 1'b0;
      game_over          = 1'b0;
      increment_score[0] = 1'b0;
      increment_score[1] = 1'b0;

      case (state)
         SERVE_WAIT: begin
            if (fsync) begin
               cnt_next = cnt - 1'b1;
               if (cnt == CW'(1))
                  state_next = PLAY;
            end
         end
         PLAY: begin
            ball_freeze = 1'b0;
            if (fsync) begin
               // Left goal is checked first
               if (bx_wide < 13'sd0) begin
                  winner_next = 1'b1;
                  state_next  = SCORE;
               end else if (bx_wide > RIGHT_LIMIT) begin
                  winner_next = 1'b0;
                  state_next  = SCORE;
               end
            end
         end
         SCORE: begin
            increment_score[0] = ~winner;
            increment_score[1] = winner;
            if (fsync) begin
               if (winner)
                  points_next[1] = win_pts_inc[3:0];
               else
                  points_next[0] = win_pts_inc[3:0];
               state_next = (win_pts_inc == 5'(WIN_POINTS)) ? GAME_OVER : RECENTER;
            end
         end
         RECENTER: begin
            ball_reset     = 1'b1;
            serve_dir_next = ~winner;
            cnt_next       = CW'(SERVE_FRAMES);
            state_next     = SERVE_WAIT;
         end
         GAME_OVER: begin
            game_over = 1'b1;
            if (start) begin
               points_next[0] = '0;
               points_next[1] = '0;
               state_next     = RECENTER;
            end
         end
         default: state_next = SERVE_WAIT;
      endcase
   end

endmodule

// File: tb/tb_point_referee.sv
// tb/tb_point_referee.sv - directed self-checking bench for point_referee.
// A small scoreboard model counts increments seen on fsync.
module tb_point_referee;

   logic               pixel_clk = 1'b0;
   logic               rst;
   logic               fsync;
   logic signed [11:0] ball_x;
   logic               start;
   logic               increment_score [1:0];
   logic               ball_freeze;
   logic               ball_reset;
   logic               serve_dir;
   logic               game_over;

   int checks = 0;
   int errors = 0;
   int sc0 = 0;
   int sc1 = 0;

   point_referee #(
      .HRES(1280),
      .BALL_SIZE(20),
      .SERVE_FRAMES(3),
      .WIN_POINTS(10)
   ) dut (
      .pixel_clk(pixel_clk),
      .rst(rst),
      .fsync(fsync),
      .ball_x(ball_x),
      .start(start),
      .increment_score(increment_score),
      .ball_freeze(ball_freeze),
      .ball_reset(ball_reset),
      .serve_dir(serve_dir),
      .game_over(game_over)
   );

   always #5 pixel_clk = ~pixel_clk;

   // Scoreboard acts only on fsync
   always @(posedge pixel_clk) begin
      if (fsync) begin
         if (increment_score[0] === 1'b1) sc0 = sc0 + 1;
         if (increment_score[1] === 1'b1) sc1 = sc1 + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, want);
      end
   endtask

   // Two idle cycles, then one fsync cycle; returns on the negedge after the fsync edge
   task automatic frame(input logic signed [11:0] bx);
      repeat (2) @(negedge pixel_clk);
      ball_x = bx;
      fsync  = 1'b1;
      @(negedge pixel_clk);
      fsync  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_freeze"}, ball_freeze, 1);
      check({tag, "_inc0"}, increment_score[0], 0);
      check({tag, "_inc1"}, increment_score[1], 0);
      check({tag, "_breset"}, ball_reset, 0);
      check({tag, "_gover"}, game_over, 0);
      check({tag, "_sdir"}, serve_dir, 0);
   endtask

   initial begin
      rst    = 1'b1;
      fsync  = 1'b0;
      start  = 1'b0;
      ball_x = 12'sd600;
      repeat (2) @(negedge pixel_clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      frame(12'sd600);
      check("t1_fs1_freeze", ball_freeze, 1);
      frame(12'sd600);
      check("t1_fs2_freeze", ball_freeze, 1);
      frame(12'sd600);
      check("t1_fs3_freeze", ball_freeze, 0);

      ball_x = -12'sd5;
      @(negedge pixel_clk);
      ball_x = 12'sd600;
      frame(12'sd600);
      check("t4_glitch_freeze", ball_freeze, 0);
      check("t4_glitch_inc1", increment_score[1], 0);

      frame(12'sd1260);
      check("t3_edge_freeze", ball_freeze, 0);
      check("t3_edge_inc0", increment_score[0], 0);

      frame(-12'sd1);
      check("t2_inc1", increment_score[1], 1);
      check("t2_inc0", increment_score[0], 0);
      check("t2_freeze", ball_freeze, 1);
      repeat (1000) @(negedge pixel_clk);
      check("t4_hold_inc1", increment_score[1], 1);
      check("t4_hold_sc1", sc1, 0);
      frame(12'sd600);
      check("t2_breset", ball_reset, 1);
      check("t2_inc1_off", increment_score[1], 0);
      check("t4_sc1_once", sc1, 1);
      @(negedge pixel_clk);
      check("t2_breset_off", ball_reset, 0);
      check("t2_sdir", serve_dir, 0);
      check("t2_sc0", sc0, 0);

      start = 1'b1;
      @(negedge pixel_clk);
      start = 1'b0;
      check("start_ign_breset", ball_reset, 0);
      check("start_ign_gover", game_over, 0);

      repeat (3) frame(12'sd600);
      check("t3_play_freeze", ball_freeze, 0);
      frame(12'sd1261);
      check("t3_inc0", increment_score[0], 1);
      check("t3_inc1", increment_score[1], 0);
      frame(12'sd600);
      check("t3_breset", ball_reset, 1);
      @(negedge pixel_clk);
      check("t3_sdir", serve_dir, 1);
      check("t3_sc0", sc0, 1);

      for (int i = 0; i < 9; i++) begin
         repeat (3) frame(12'sd600);
         frame(12'sd1261);
         frame(12'sd600);
         if (i < 8) check("t5_no_gover", game_over, 0);
      end
      check("t5_gover", game_over, 1);
      check("t5_freeze", ball_freeze, 1);
      check("t5_inc0", increment_score[0], 0);
      check("t5_breset", ball_reset, 0);
      check("t5_sc0", sc0, 10);

      repeat (3) frame(-12'sd1);
      check("t5_ign_gover", game_over, 1);
      check("t5_ign_sc0", sc0, 10);
      check("t5_ign_sc1", sc1, 1);
      check("t5_ign_inc1", increment_score[1], 0);

      start = 1'b1;
      @(negedge pixel_clk);
      start = 1'b0;
      check("t5_start_breset", ball_reset, 1);
      check("t5_start_gover", game_over, 0);
      @(negedge pixel_clk);
      check("t5_start_sdir", serve_dir, 1);
      check("t5_start_breset_off", ball_reset, 0);

      repeat (3) frame(12'sd600);
      frame(12'sd1261);
      frame(12'sd600);
      check("t5_cleared_gover", game_over, 0);
      check("t5_cleared_breset", ball_reset, 1);
      check("t5_cleared_sc0", sc0, 11);

      repeat (3) frame(12'sd600);
      frame(-12'sd1);
      check("t6_inc1", increment_score[1], 1);
      repeat (5) @(negedge pixel_clk);
      rst = 1'b1;
      @(negedge pixel_clk);
      rst = 1'b0;
      check_reset_outputs("t6");
      frame(12'sd600);
      check("t6_sc1", sc1, 1);
      check("t6_inc1_after", increment_score[1], 0);
      check("t6_freeze_after", ball_freeze, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
